// File: rtl/cpu_debug_pkg.sv
// Shared types and constants for the CPU debug reporter.
// Frame layout constants and the HLT opcode live here.
package cpu_debug_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        SEND    = 3'd2,
        WAIT_TX = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam int         FRAME_LEN = 8;
    localparam logic [4:0] HLT_OP    = 5'b00000;

endpackage

// File: rtl/debug_frame_mux.sv
// Selects one byte of the 8-byte result frame by index.
// Byte 7 is the XOR checksum of bytes 1..6.
module debug_frame_mux
    import cpu_debug_pkg::*;
(
    input  logic [2:0]  idx,
    input  logic [15:0] pc,
    input  logic [15:0] acc,
    input  logic [15:0] cyc,
    output logic [7:0]  frame_byte
);

    logic [7:0] checksum;

    assign checksum = pc[15:8] ^ pc[7:0] ^ acc[15:8] ^ acc[7:0]
                    ^ cyc[15:8] ^ cyc[7:0];

    // Byte selector over the fixed frame layout
    always_comb begin
        frame_byte = FRAME_HDR;
        unique case (idx)
            3'd0: frame_byte = FRAME_HDR;
            3'd1: frame_byte = pc[15:8];
            3'd2: frame_byte = pc[7:0];
            3'd3: frame_byte = acc[15:8];
            3'd4: frame_byte = acc[7:0];
            3'd5: frame_byte = cyc[15:8];
            3'd6: frame_byte = cyc[7:0];
            3'd7: frame_byte = checksum;
        endcase
    end

endmodule

// File: rtl/cpu_debug_reporter.sv
// Runs the CPU until HLT, counts cycles, then streams
// the result frame to the UART TX one byte per handshake.
module cpu_debug_reporter
    import cpu_debug_pkg::*;
#(
    parameter int N_BUS    = 16,
    parameter int N_BUS_IN = 11,
    parameter int N_OP     = 5,
    parameter int N_BYTE   = 8,
    parameter int N_CYC    = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [N_BUS-1:0]    i_instr,
    input  logic [N_BUS_IN-1:0] i_PC,
    input  logic [N_BUS-1:0]    i_acc,
    input  logic                i_tx_done,
    output logic                o_cpu_en,
    output logic                o_tx_start,
    output logic [N_BYTE-1:0]   o_tx_data,
    output logic                o_done
);

    state_t           state;
    logic [N_CYC-1:0] cyc;
    logic [N_CYC-1:0] cyc_inc;
    logic [15:0]      pc_q;
    logic [15:0]      acc_q;
    logic [15:0]      cyc_q;
    logic [2:0]       idx;
    logic [2:0]       sel_idx;
    logic [7:0]       frame_byte;
    logic             is_hlt;

    assign is_hlt  = (i_instr[N_BUS-1 -: N_OP] == N_OP'(HLT_OP));
    assign cyc_inc = (&cyc) ? cyc : cyc + N_CYC'(1);

    // Outputs are registered, so the mux looks at the byte about to be sent
    assign sel_idx = (state == WAIT_TX) ? idx + 3'd1 : 3'd0;

    debug_frame_mux u_mux (
        .idx        (sel_idx),
        .pc         (pc_q),
        .acc        (acc_q),
        .cyc        (cyc_q),
        .frame_byte (frame_byte)
    );

    // Control FSM with cycle counter, halt latches and frame sequencing
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            cyc        <= '0;
            pc_q       <= '0;
            acc_q      <= '0;
            cyc_q      <= '0;
            idx        <= '0;
            o_cpu_en   <= 1'b0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_done     <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        state    <= RUN;
                        o_cpu_en <= 1'b1;
                        cyc      <= '0;
                    end
                end
                RUN: begin
                    cyc <= cyc_inc;
                    if (is_hlt) begin
                        pc_q       <= 16'(i_PC);
                        acc_q      <= 16'(i_acc);
                        cyc_q      <= 16'(cyc_inc);
                        idx        <= '0;
                        o_cpu_en   <= 1'b0;
                        o_tx_data  <= N_BYTE'(frame_byte);
                        o_tx_start <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (i_tx_done) begin
                        if (idx == 3'(FRAME_LEN - 1)) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            idx        <= idx + 3'd1;
                            o_tx_data  <= N_BYTE'(frame_byte);
                            o_tx_start <= 1'b1;
                            state      <= SEND;
                        end
                    end
                end
                DONE: begin
                    o_done   <= 1'b1;
                    o_cpu_en <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_debug_reporter.sv
// Testbench for cpu_debug_reporter: vector table of runs,
// expected frame bytes queued at halt and popped per TX start.
module tb_cpu_debug_reporter;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_instr = 16'h0800;
    logic [10:0] i_PC = '0;
    logic [15:0] i_acc = '0;
    logic        i_tx_done = 1'b0;
    logic        o_cpu_en;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        o_done;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        int          run;
        logic [15:0] run_instr;
        logic [15:0] halt_instr;
        logic [10:0] pc;
        logic [15:0] acc;
        int          delay;
        bit          spur;
        int          abort_at;
        logic [15:0] exp_cyc;
    } vec_t;

    vec_t vt[5];

    cpu_debug_reporter dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_instr    (i_instr),
        .i_PC       (i_PC),
        .i_acc      (i_acc),
        .i_tx_done  (i_tx_done),
        .o_cpu_en   (o_cpu_en),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_frame(input logic [15:0] pc,
                                       input logic [15:0] acc,
                                       input logic [15:0] cyc);
        logic [7:0] b[8];
        b[0] = 8'hA5;
        b[1] = pc[15:8];
        b[2] = pc[7:0];
        b[3] = acc[15:8];
        b[4] = acc[7:0];
        b[5] = cyc[15:8];
        b[6] = cyc[7:0];
        b[7] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6];
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    endfunction

    task automatic do_reset();
        i_reset = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    task automatic run_vector(input int vi, input vec_t v,
                              output bit aborted);
        int         en_cnt;
        int         t;
        bit         bad;
        logic [7:0] held;
        logic [7:0] exp;
        aborted = 1'b0;
        i_instr = v.run_instr;
        i_PC    = '0;
        i_acc   = '0;
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        en_cnt = 0;
        for (int k = 0; k < v.run; k++) begin
            if (o_cpu_en) en_cnt++;
            if (v.spur && k == v.run / 2) begin
                i_start   = 1'b1;
                i_tx_done = 1'b1;
            end
            @(negedge i_clk);
            i_start   = 1'b0;
            i_tx_done = 1'b0;
        end
        if (o_cpu_en) en_cnt++;
        i_instr = v.halt_instr;
        i_PC    = v.pc;
        i_acc   = v.acc;
        push_frame(16'(v.pc), v.acc, v.exp_cyc);
        @(negedge i_clk);
        i_instr = v.run_instr;
        i_PC    = 11'h7AB;
        i_acc   = 16'hDEAD;
        chk($sformatf("v%0d cpu_en_cycles", vi), en_cnt, v.run + 1);
        for (int b = 0; b < 8; b++) begin
            t = 0;
            while (!o_tx_start && t < 8) begin
                @(negedge i_clk);
                t++;
            end
            chk($sformatf("v%0d b%0d start_latency", vi, b), t, 0);
            if (t >= 8) return;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            chk($sformatf("v%0d b%0d tx_data", vi, b), o_tx_data, exp);
            chk($sformatf("v%0d b%0d cpu_en_off", vi, b), o_cpu_en, 0);
            held = o_tx_data;
            @(negedge i_clk);
            chk($sformatf("v%0d b%0d start_width", vi, b), o_tx_start, 0);
            if (b == v.abort_at) begin
                #2 i_reset = 1'b1;
                #1;
                chk($sformatf("v%0d rst tx_start", vi), o_tx_start, 0);
                chk($sformatf("v%0d rst cpu_en", vi), o_cpu_en, 0);
                chk($sformatf("v%0d rst done", vi), o_done, 0);
                chk($sformatf("v%0d rst tx_data", vi), o_tx_data, 0);
                exp_q.delete();
                @(negedge i_clk);
                i_reset = 1'b0;
                aborted = 1'b1;
                return;
            end
            bad = 1'b0;
            for (int d = 0; d < v.delay; d++) begin
                if (o_tx_data !== held || o_tx_start) bad = 1'b1;
                @(negedge i_clk);
            end
            if (o_tx_data !== held) bad = 1'b1;
            chk($sformatf("v%0d b%0d data_stable", vi, b), bad, 0);
            chk($sformatf("v%0d b%0d done_early", vi, b), o_done, 0);
            i_tx_done = 1'b1;
            @(negedge i_clk);
            i_tx_done = 1'b0;
        end
        chk($sformatf("v%0d done", vi), o_done, 1);
        chk($sformatf("v%0d queue_empty", vi), exp_q.size(), 0);
        i_start   = 1'b1;
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_start   = 1'b0;
        i_tx_done = 1'b0;
        bad = 1'b0;
        for (int d = 0; d < 4; d++) begin
            if (!o_done || o_cpu_en || o_tx_start) bad = 1'b1;
            @(negedge i_clk);
        end
        chk($sformatf("v%0d done_hold", vi), bad, 0);
    endtask

    initial begin
        bit aborted;
        bit prev_aborted;
        vt[0] = '{0, 16'h0800, 16'h0000, 11'h000, 16'h0000,
                  0, 1'b0, -1, 16'h0001};
        vt[1] = '{5, 16'hF800, 16'h0000, 11'h005, 16'h1234,
                  20, 1'b1, -1, 16'h0006};
        vt[2] = '{3, 16'h0800, 16'h07FF, 11'h7FF, 16'hBEEF,
                  2, 1'b0, 3, 16'h0004};
        vt[3] = '{10, 16'h0800, 16'h0123, 11'h123, 16'hFFFF,
                  1, 1'b1, -1, 16'h000B};
        vt[4] = '{70000, 16'h8000, 16'h0000, 11'h2AA, 16'h5555,
                  0, 1'b0, -1, 16'hFFFF};

        #1;
        chk("reset cpu_en", o_cpu_en, 0);
        chk("reset tx_start", o_tx_start, 0);
        chk("reset tx_data", o_tx_data, 0);
        chk("reset done", o_done, 0);

        prev_aborted = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!prev_aborted) do_reset();
            run_vector(i, vt[i], aborted);
            prev_aborted = aborted;
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
